lockout_sequencer: RTL and testbench

Timing controller for the password-lock datapath. It tracks the entry session and times the PASS and FAIL result displays. It schedules escalating lockouts after failed attempts and enforces an inactivity timeout. It also gates when button input is accepted. It sits between the debounced button front end / password comparator and the LED driver, using a shared one-second prescaler.

---
 rtl/lockout_sequencer_if.sv | 37 +++
 rtl/lockout_sequencer.sv | 147 ++++++++++++++
 tb/tb_lockout_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lockout_sequencer_if.sv
// lockout_sequencer_if
// Bundles the button/comparator inputs and the status outputs of the lockout
// sequencer.
//   activity      : 1-cycle pulse per accepted enter0/enter1/clear press
//   verify_valid  : 1-cycle pulse, comparator result available
//   verify_ok     : qualifies verify_valid, 1 = password match
//   state_o       : IDLE=0, ENTRY=1, PASS=2, FAIL=3, LOCK=4
//   accept_input  : high in IDLE and ENTRY
//   session_clear : 1-cycle pulse in the first IDLE cycle after another state
//   timeout_pulse : 1-cycle pulse on inactivity timeout
//   fail_count    : consecutive failures, saturating at 3
//   secs_left     : whole seconds remaining in the timed state, 0 in IDLE
// The master modport drives the inputs (front end); the slave modport is the
// sequencer itself.
interface lockout_sequencer_if;
    logic       activity;
    logic       verify_valid;
    logic       verify_ok;
    logic [2:0] state_o;
    logic       accept_input;
    logic       session_clear;
    logic       timeout_pulse;
    logic [1:0] fail_count;
    logic [6:0] secs_left;

    modport master (
        output activity, verify_valid, verify_ok,
        input  state_o, accept_input, session_clear, timeout_pulse,
               fail_count, secs_left
    );

    modport slave (
        input  activity, verify_valid, verify_ok,
        output state_o, accept_input, session_clear, timeout_pulse,
               fail_count, secs_left
    );
endinterface

// File: rtl/lockout_sequencer.sv
// lockout_sequencer
// Session/result/lockout timing controller for the password lock. Tracks the
// entry session, holds PASS and FAIL displays, applies escalating lockouts
// after failures and times out an idle entry session.
// Ports:
//   clock : system clock
//   reset : asynchronous, active-high
//   bus   : lockout_sequencer_if.slave (inputs activity/verify_valid/verify_ok,
//           status outputs state_o/accept_input/session_clear/timeout_pulse/
//           fail_count/secs_left)
// All outputs come from registers.
module lockout_sequencer #(
    parameter int unsigned CYCLES_PER_SEC   = 25_000_000,
    parameter int unsigned PASS_SEC         = 6,
    parameter int unsigned FAIL_SEC         = 6,
    parameter int unsigned LOCK_BASE_SEC    = 15,
    parameter int unsigned LOCK_MAX_SEC     = 60,
    parameter int unsigned IDLE_TIMEOUT_SEC = 60
) (
    input  logic                clock,
    input  logic                reset,
    lockout_sequencer_if.slave  bus
);

    localparam int unsigned PW = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CYCLES_PER_SEC - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_PASS  = 3'd2,
        ST_FAIL  = 3'd3,
        ST_LOCK  = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [6:0]    secs;
    logic [1:0]    fail_count;
    logic          session_clear;
    logic          timeout_pulse;
    logic          wrap;
    logic          expire;
    logic          entry_timeout;

    // Seconds to load on entering a state. For LOCK, fc is the already
    // incremented failure count (it updates on FAIL entry, before LOCK).
    function automatic logic [6:0] duration(state_t s, logic [1:0] fc);
        int unsigned d;
        int unsigned sh;
        d  = 0;
        sh = 0;
        case (s)
            ST_ENTRY: d = IDLE_TIMEOUT_SEC;
            ST_PASS:  d = PASS_SEC;
            ST_FAIL:  d = FAIL_SEC;
            ST_LOCK: begin
                if (fc != 2'd0) sh = 32'(fc) - 32'd1;
                d = LOCK_BASE_SEC << sh;
                if (d > LOCK_MAX_SEC) d = LOCK_MAX_SEC;
            end
            default:  d = 0;
        endcase
        return d[6:0];
    endfunction

    assign wrap   = (presc == PRESC_LAST);
    // Last cycle of a timed state: the wrap that takes the seconds from 1 to 0.
    assign expire = wrap && (secs == 7'd1);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic; verify beats activity, activity beats expiry in ENTRY.
    always_comb begin
        state_next    = state;
        entry_timeout = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.verify_valid)  state_next = bus.verify_ok ? ST_PASS : ST_FAIL;
                else if (bus.activity) state_next = ST_ENTRY;
            end
            ST_ENTRY: begin
                if (bus.verify_valid) begin
                    state_next = bus.verify_ok ? ST_PASS : ST_FAIL;
                end else if (!bus.activity && expire) begin
                    state_next    = ST_IDLE;
                    entry_timeout = 1'b1;
                end
            end
            ST_PASS: if (expire) state_next = ST_IDLE;
            ST_FAIL: if (expire) state_next = ST_LOCK;
            ST_LOCK: if (expire) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Timer, failure counter and the registered pulses
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc         <= '0;
            secs          <= '0;
            fail_count    <= '0;
            session_clear <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            session_clear <= (state_next == ST_IDLE) && (state != ST_IDLE);
            timeout_pulse <= entry_timeout;

            if (state_next != state) begin
                if (state_next == ST_PASS) fail_count <= '0;
                else if (state_next == ST_FAIL && fail_count != 2'd3)
                    fail_count <= fail_count + 2'd1;
            end

            if (state_next != state) begin
                presc <= '0;
                secs  <= duration(state_next, fail_count);
            end else if (state == ST_ENTRY && bus.activity) begin
                presc <= '0;
                secs  <= IDLE_TIMEOUT_SEC[6:0];
            end else if (state != ST_IDLE) begin
                if (wrap) begin
                    presc <= '0;
                    secs  <= secs - 7'd1;
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

    // Output logic
    always_comb begin
        bus.state_o       = state;
        bus.accept_input  = (state == ST_IDLE) || (state == ST_ENTRY);
        bus.session_clear = session_clear;
        bus.timeout_pulse = timeout_pulse;
        bus.fail_count    = fail_count;
        bus.secs_left     = secs;
    end

endmodule

// File: tb/tb_lockout_sequencer.sv
// tb_lockout_sequencer
// Directed bench for lockout_sequencer with CYCLES_PER_SEC=10. A cycle-count
// model (remaining cycles in the current state) predicts every output and is
// compared on each falling edge; literal durations and counts pin the model.
module tb_lockout_sequencer;

    localparam int CPS = 10;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   started = 1'b0;

    lockout_sequencer_if bus();

    lockout_sequencer #(
        .CYCLES_PER_SEC  (CPS),
        .PASS_SEC        (6),
        .FAIL_SEC        (6),
        .LOCK_BASE_SEC   (15),
        .LOCK_MAX_SEC    (60),
        .IDLE_TIMEOUT_SEC(60)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    int m_state = 0;   // 0 idle,1 entry,2 pass,3 fail,4 lock
    int m_rem   = 0;   // cycles remaining in the current timed state
    int m_fc    = 0;
    bit m_clr   = 1'b0;
    bit m_to    = 1'b0;
    int m_nxt;
    bit m_reload;

    function automatic int secs_for(int s, int fc);
        int d;
        case (s)
            1: d = 60;
            2: d = 6;
            3: d = 6;
            4: begin
                d = 15;
                for (int i = 1; i < fc; i++) d = d * 2;
                if (d > 60) d = 60;
            end
            default: d = 0;
        endcase
        return d;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_state = 0; m_rem = 0; m_fc = 0; m_clr = 1'b0; m_to = 1'b0;
        end else begin
            m_nxt = m_state; m_reload = 1'b0; m_clr = 1'b0; m_to = 1'b0;
            case (m_state)
                0: if (bus.verify_valid) m_nxt = bus.verify_ok ? 2 : 3;
                   else if (bus.activity) m_nxt = 1;
                1: if (bus.verify_valid) m_nxt = bus.verify_ok ? 2 : 3;
                   else if (bus.activity) m_reload = 1'b1;
                   else if (m_rem == 1) begin m_nxt = 0; m_to = 1'b1; end
                2: if (m_rem == 1) m_nxt = 0;
                3: if (m_rem == 1) m_nxt = 4;
                4: if (m_rem == 1) m_nxt = 0;
                default: m_nxt = 0;
            endcase
            if (m_nxt != m_state) begin
                if (m_nxt == 0) m_clr = 1'b1;
                if (m_nxt == 2) m_fc = 0;
                if (m_nxt == 3 && m_fc < 3) m_fc++;
                m_rem   = secs_for(m_nxt, m_fc) * CPS;
                m_state = m_nxt;
            end else if (m_reload) begin
                m_rem = 60 * CPS;
            end else if (m_state != 0) begin
                m_rem--;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int e_secs;
    always @(negedge clock) begin
        if (started) begin
            e_secs = (m_state == 0) ? 0 : (m_rem + CPS - 1) / CPS;
            checks++;
            if (int'(bus.state_o) != m_state ||
                bus.accept_input != (m_state <= 1) ||
                bus.session_clear != m_clr ||
                bus.timeout_pulse != m_to ||
                int'(bus.fail_count) != m_fc ||
                int'(bus.secs_left) != e_secs) begin
                errors++;
                $display("FAIL model_cycle t=%0t: got st=%0d acc=%0b clr=%0b to=%0b fc=%0d secs=%0d, required st=%0d acc=%0b clr=%0b to=%0b fc=%0d secs=%0d",
                         $time, bus.state_o, bus.accept_input, bus.session_clear,
                         bus.timeout_pulse, bus.fail_count, bus.secs_left,
                         m_state, (m_state <= 1), m_clr, m_to, m_fc, e_secs);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    task automatic pulse(input logic a, input logic v, input logic ok);
        bus.activity = a; bus.verify_valid = v; bus.verify_ok = ok;
        tick();
        bus.activity = 1'b0; bus.verify_valid = 1'b0; bus.verify_ok = 1'b0;
    endtask

    task automatic expect_eq(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, actual, required);
        end
    endtask

    task automatic wait_leave(input int s, input int budget);
        int n;
        n = 0;
        while (int'(bus.state_o) == s && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_leave_state%0d: still in state after %0d cycles, required exit", s, n);
        end
    endtask

    // One failed attempt from IDLE; returns the LOCK length in cycles.
    task automatic fail_cycle(input int fc_req, input bit gate, output int lock_cyc);
        int t0;
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        tick();
        pulse(1'b0, 1'b1, 1'b0);
        expect_eq("fail_state", int'(bus.state_o), 3);
        expect_eq("fail_count", int'(bus.fail_count), fc_req);
        t0 = cyc;
        wait_leave(3, 100);
        expect_eq("fail_len", cyc - t0, 60);
        expect_eq("lock_state", int'(bus.state_o), 4);
        t0 = cyc;
        if (gate) begin
            repeat (20) tick();
            pulse(1'b1, 1'b1, 1'b1);
            expect_eq("gate_state", int'(bus.state_o), 4);
            expect_eq("gate_secs", int'(bus.secs_left), 13);
            expect_eq("gate_accept", int'(bus.accept_input), 0);
        end
        wait_leave(4, 700);
        lock_cyc = cyc - t0;
        expect_eq("lock_exit_state", int'(bus.state_o), 0);
        expect_eq("lock_exit_clear", int'(bus.session_clear), 1);
    endtask

    // ---------------- directed stimulus ----------------
    int t0;
    int len;
    int lock_tab[4] = '{150, 300, 600, 600};
    int fc_tab[4]   = '{1, 2, 3, 3};

    initial begin
        bus.activity = 1'b0; bus.verify_valid = 1'b0; bus.verify_ok = 1'b0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        started = 1'b1;
        expect_eq("rst_state", int'(bus.state_o), 0);
        expect_eq("rst_accept", int'(bus.accept_input), 1);
        expect_eq("rst_clear", int'(bus.session_clear), 0);
        expect_eq("rst_timeout", int'(bus.timeout_pulse), 0);
        expect_eq("rst_fc", int'(bus.fail_count), 0);
        expect_eq("rst_secs", int'(bus.secs_left), 0);

        // Success: verify 5 cycles after the first activity
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        expect_eq("entry_state", int'(bus.state_o), 1);
        expect_eq("entry_secs", int'(bus.secs_left), 60);
        repeat (4) tick();
        pulse(1'b0, 1'b1, 1'b1);
        expect_eq("pass_state", int'(bus.state_o), 2);
        expect_eq("pass_secs", int'(bus.secs_left), 6);
        t0 = cyc;
        wait_leave(2, 100);
        expect_eq("pass_len", cyc - t0, 60);
        expect_eq("pass_exit_state", int'(bus.state_o), 0);
        expect_eq("pass_exit_clear", int'(bus.session_clear), 1);
        expect_eq("pass_fc", int'(bus.fail_count), 0);

        // Escalating lockout, four consecutive failures
        for (int i = 0; i < 4; i++) begin
            fail_cycle(fc_tab[i], 1'b0, len);
            expect_eq("lock_len", len, lock_tab[i]);
        end

        // Recovery: two failures, a success, then a fresh 150-cycle lock
        tick();
        pulse(1'b0, 1'b1, 1'b1);
        wait_leave(2, 100);
        fail_cycle(1, 1'b0, len);
        fail_cycle(2, 1'b0, len);
        expect_eq("recov_lock2", len, 300);
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b1);
        expect_eq("recov_fc", int'(bus.fail_count), 0);
        wait_leave(2, 100);
        fail_cycle(1, 1'b1, len);
        expect_eq("recov_lock", len, 150);

        // Inactivity timeout
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        wait_leave(1, 700);
        expect_eq("idle_len", cyc - t0, 600);
        expect_eq("idle_timeout", int'(bus.timeout_pulse), 1);
        expect_eq("idle_clear", int'(bus.session_clear), 1);
        expect_eq("idle_fc", int'(bus.fail_count), 1);

        // Activity in the expiry cycle pushes the timeout out
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        t0 = cyc;
        repeat (599) tick();
        pulse(1'b1, 1'b0, 1'b0);
        expect_eq("late_act_state", int'(bus.state_o), 1);
        wait_leave(1, 1300);
        expect_eq("late_act_len", cyc - t0, 1200);
        expect_eq("late_act_timeout", int'(bus.timeout_pulse), 1);

        // Failed verify coinciding with expiry
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        repeat (599) tick();
        pulse(1'b0, 1'b1, 1'b0);
        expect_eq("coll_state", int'(bus.state_o), 3);
        expect_eq("coll_timeout", int'(bus.timeout_pulse), 0);
        expect_eq("coll_fc", int'(bus.fail_count), 2);
        wait_leave(3, 100);
        t0 = cyc;
        wait_leave(4, 700);
        expect_eq("coll_lock", cyc - t0, 300);

        // Async reset mid-LOCK, between edges
        tick();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        wait_leave(3, 100);
        repeat (50) tick();
        expect_eq("pre_rst_state", int'(bus.state_o), 4);
        #2 reset = 1'b1;
        #1;
        expect_eq("arst_state", int'(bus.state_o), 0);
        expect_eq("arst_fc", int'(bus.fail_count), 0);
        expect_eq("arst_accept", int'(bus.accept_input), 1);
        expect_eq("arst_secs", int'(bus.secs_left), 0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        expect_eq("post_rst_state", int'(bus.state_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
